alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Registered, parametrised successor to the single-cycle ALU control decoder.
//  - Decodes ALUOp/Funct3/Funct7 (plus an I-type flag) into a one-hot-free operation code.
//  - Covers base RV32I ALU ops, the six branch compares, PASS_B, and optionally the RV32M ops.
//  - Presents the result through a valid/ready output register in the ID/EX boundary.
//  - Sequences multi-cycle MUL/DIV occupancy so the front end stalls while the MDU is busy.
// PARAMETERS
//  OP_W      5   width of Operation; must be >= 5
//  ENABLE_M  1   1: decode Funct7=0000001 as M-extension ops; 0: those encodings are illegal
//  MUL_LAT   3   MDU cycles for MUL/MULH/MULHSU/MULHU; >= 1
//  DIV_LAT   33  MDU cycles for DIV/DIVU/REM/REMU; >= 1
//  (localparam CNT_W = $clog2(max(MUL_LAT,DIV_LAT)+1))
// PORTS
//  clk          in   1     clock; all state updates on the rising edge
//  reset        in   1     synchronous, active-high reset
//  flush        in   1     synchronous pipeline flush
//  in_valid     in   1     decode request valid
//  in_ready     out  1     request accepted when in_valid && in_ready
//  ALUOp        in   2     00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI
//  Funct7       in   7     instr[31:25]
//  Funct3       in   3     instr[14:12]
//  IsImm        in   1     1 = I-type ALU instruction (Funct7 only significant for shifts)
//  out_valid    out  1     Operation/flags valid
//  out_ready    in   1     downstream accepts when out_valid && out_ready
//  Operation    out  OP_W  alu_op_e code
//  out_mdu      out  1     op executes in the multi-cycle MDU
//  out_illegal  out  1     encoding not decodable; Operation forced to OP_ADD
//  busy         out  1     MDU occupancy in progress (state WAIT)
//  mdu_done     out  1     one-cycle pulse on the final MDU occupancy cycle
// BEHAVIOUR
//  Reset: out_valid=0, Operation=OP_ADD, out_mdu=0, out_illegal=0, busy=0, mdu_done=0, state IDLE, counter 0.
//  Decode:
//   - ALUOp 00 -> ADD.
//   - ALUOp 11 -> PASS_B.
//   - ALUOp 01, Funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 illegal.
//   - ALUOp 10, IsImm=1:
//     - 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND; Funct7 ignored for these.
//     - 001 SLL requires Funct7=0; 101 is SRL (Funct7=0) or SRA (0100000); any other Funct7 illegal.
//   - ALUOp 10, IsImm=0:
//     - Funct7=0000000: standard R ops.
//     - Funct7=0100000: 000 SUB, 101 SRA; other Funct3 illegal.
//     - Funct7=0000001 with ENABLE_M: Funct3 000..111 -> MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; out_mdu=1.
//     - Any other Funct7 illegal.
//  Latency: 1 cycle from accept to out_valid.
//  Handshake:
//   - in_ready = (!out_valid || out_ready) && state!=WAIT && !flush.
//   - Output register holds stable while out_valid && !out_ready.
//  FSM IDLE/WAIT:
//   - On output handshake with out_mdu=1 and latency L>1: go WAIT, counter=L-1. L=1 stays IDLE and pulses mdu_done that cycle.
//   - In WAIT: counter decrements each cycle; mdu_done=1 when counter==1; next cycle -> IDLE. busy=1 throughout WAIT.
//  Simultaneous accept and output handshake (pipelined streaming):
//   - Allowed for non-MDU outputs.
//   - If the handshaking output has out_mdu=1, in_ready is still 1 that cycle; the new op is registered and waits in the output stage.
//  Flush (priority reset > flush > handshakes):
//   - Next cycle out_valid=0, state IDLE, counter 0, no mdu_done.
//   - Input offered in the flush cycle is dropped.
//  Illegal encodings propagate as normal transactions (out_illegal=1); they never enter WAIT.
// STRUCTURE
//  - Package alu_ctrl_pkg:
//    - alu_op_e: ADD=0, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, EQ, NE, LT, GE, LTU, GEU, MUL=16..REMU=23, PASS_B=24.
//    - ALUOP_MEM/BR/RI/JL constants; F7_BASE/F7_ALT/F7_MULDIV constants; state enum.
//  - Sub-module alu_op_decode: purely combinational decode, parametrised by ENABLE_M.
//    Top level holds the output register, FSM and counter.
// TESTING
//  1. Reset held 2 cycles -> all outputs at reset values, in_ready=1 after release.
//  2. R add (ALUOp=10, F7=00, F3=000) then sub (F7=20) with out_ready=1 -> Operation 0 then 1 on consecutive cycles, one per clk.
//  3. I-type IsImm=1, F3=000, F7=0100000 -> ADD, not SUB; IsImm=1, F3=001, F7=0100000 -> out_illegal=1.
//  4. DIV_LAT=4: R F7=01, F3=100 -> Operation=20, out_mdu=1.
//     After handshake busy=1 for 3 cycles, mdu_done on the 3rd, in_ready=0 during busy.
//  5. out_ready=0 for 5 cycles with a new in_valid -> in_ready=0, Operation stable; release -> next op follows.
//  6. flush during WAIT of DIV -> next cycle busy=0, out_valid=0, no mdu_done.
//     ENABLE_M=0 with F7=01 -> out_illegal=1, out_mdu=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the ALU issue controller: operation codes,
// ALUOp/Funct7 constants, FSM states and the decode result payload.
package alu_ctrl_pkg;

  localparam int unsigned ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_EQ     = 5'd10,
    OP_NE     = 5'd11,
    OP_LT     = 5'd12,
    OP_GE     = 5'd13,
    OP_LTU    = 5'd14,
    OP_GEU    = 5'd15,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23,
    OP_PASS_B = 5'd24
  } alu_op_e;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_RI  = 2'b10;
  localparam logic [1:0] ALUOP_JL  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } issue_state_e;

  typedef struct packed {
    alu_op_e op;
    logic    mdu;
    logic    illegal;
  } dec_res_t;

  // Multiply group uses MUL_LAT; the remaining MDU ops use DIV_LAT.
  function automatic logic is_mul_op(alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Purely combinational ALUOp/Funct3/Funct7 decode into an alu_op_e code plus
// MDU and illegal flags; illegal encodings always report OP_ADD.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [1:0] aluop,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic       is_imm,
  output dec_res_t   dec_c
);

  always_comb begin
    dec_c = '{op: OP_ADD, mdu: 1'b0, illegal: 1'b0};
    case (aluop)
      ALUOP_MEM: dec_c.op = OP_ADD;
      ALUOP_JL:  dec_c.op = OP_PASS_B;
      ALUOP_BR: begin
        case (funct3)
          3'b000:  dec_c.op = OP_EQ;
          3'b001:  dec_c.op = OP_NE;
          3'b100:  dec_c.op = OP_LT;
          3'b101:  dec_c.op = OP_GE;
          3'b110:  dec_c.op = OP_LTU;
          3'b111:  dec_c.op = OP_GEU;
          default: dec_c.illegal = 1'b1;
        endcase
      end
      default: begin
        // Immediate forms only look at Funct7 for the shift encodings.
        if (is_imm) begin
          case (funct3)
            3'b000: dec_c.op = OP_ADD;
            3'b010: dec_c.op = OP_SLT;
            3'b011: dec_c.op = OP_SLTU;
            3'b100: dec_c.op = OP_XOR;
            3'b110: dec_c.op = OP_OR;
            3'b111: dec_c.op = OP_AND;
            3'b001: begin
              if (funct7 == F7_BASE) dec_c.op = OP_SLL;
              else                   dec_c.illegal = 1'b1;
            end
            3'b101: begin
              if (funct7 == F7_BASE)     dec_c.op = OP_SRL;
              else if (funct7 == F7_ALT) dec_c.op = OP_SRA;
              else                       dec_c.illegal = 1'b1;
            end
          endcase
        end else if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000: dec_c.op = OP_ADD;
            3'b001: dec_c.op = OP_SLL;
            3'b010: dec_c.op = OP_SLT;
            3'b011: dec_c.op = OP_SLTU;
            3'b100: dec_c.op = OP_XOR;
            3'b101: dec_c.op = OP_SRL;
            3'b110: dec_c.op = OP_OR;
            3'b111: dec_c.op = OP_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  dec_c.op = OP_SUB;
            3'b101:  dec_c.op = OP_SRA;
            default: dec_c.illegal = 1'b1;
          endcase
        end else if (ENABLE_M && (funct7 == F7_MULDIV)) begin
          dec_c.mdu = 1'b1;
          case (funct3)
            3'b000: dec_c.op = OP_MUL;
            3'b001: dec_c.op = OP_MULH;
            3'b010: dec_c.op = OP_MULHSU;
            3'b011: dec_c.op = OP_MULHU;
            3'b100: dec_c.op = OP_DIV;
            3'b101: dec_c.op = OP_DIVU;
            3'b110: dec_c.op = OP_REM;
            3'b111: dec_c.op = OP_REMU;
          endcase
        end else begin
          dec_c.illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Registered ALU control decode with a valid/ready output stage and an
// IDLE/WAIT occupancy FSM that stalls issue while a MUL/DIV is in the MDU.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W     = 5,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned DIV_LAT  = 33
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            IsImm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] Operation,
  output logic            out_mdu,
  output logic            out_illegal,
  output logic            busy,
  output logic            mdu_done
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  dec_res_t         dec_c;
  issue_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_op_e          op_q, op_d;
  logic             held_q, held_d;
  logic             mdu_d, ill_d, out_valid_d;
  logic             accept_c, hs_out_c;

  alu_op_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .aluop  (ALUOp),
    .funct7 (Funct7),
    .funct3 (Funct3),
    .is_imm (IsImm),
    .dec_c  (dec_c)
  );

  assign Operation = OP_W'(op_q);

  // held_q marks an op sitting in the output stage; it stays hidden
  // (out_valid low) while the MDU is occupied by the previous op.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    held_d   = held_q;
    op_d     = op_q;
    mdu_d    = out_mdu;
    ill_d    = out_illegal;
    mdu_done = 1'b0;

    in_ready = (!out_valid || out_ready) && (state_q != ST_WAIT) && !flush;
    accept_c = in_valid && in_ready;
    hs_out_c = out_valid && out_ready && !flush;

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      held_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hs_out_c && out_mdu) begin
            if (is_mul_op(op_q)) begin
              if (MUL_LAT > 1) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(MUL_LAT - 1);
              end else begin
                mdu_done = 1'b1;
              end
            end else begin
              if (DIV_LAT > 1) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(DIV_LAT - 1);
              end else begin
                mdu_done = 1'b1;
              end
            end
          end
        end
        ST_WAIT: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            mdu_done = 1'b1;
            state_d  = ST_IDLE;
            cnt_d    = '0;
          end
        end
      endcase

      if (accept_c) begin
        held_d = 1'b1;
        op_d   = dec_c.op;
        mdu_d  = dec_c.mdu;
        ill_d  = dec_c.illegal;
      end else if (hs_out_c) begin
        held_d = 1'b0;
      end
    end

    out_valid_d = held_d && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      held_q      <= 1'b0;
      op_q        <= OP_ADD;
      out_valid   <= 1'b0;
      out_mdu     <= 1'b0;
      out_illegal <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      op_q        <= op_d;
      out_valid   <= out_valid_d;
      out_mdu     <= mdu_d;
      out_illegal <= ill_d;
      busy        <= (state_d == ST_WAIT);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: decode vector table through a
// scoreboard, plus hand-written MDU occupancy, stall, flush and no-M sequences.
module tb_alu_issue_ctrl;

  localparam int unsigned OP_W    = 5;
  localparam int unsigned MUL_LAT = 1;
  localparam int unsigned DIV_LAT = 4;

  typedef struct packed {
    logic [4:0] op;
    logic       mdu;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [1:0] aluop;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       imm;
    exp_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready, IsImm;
  logic [1:0] ALUOp;
  logic [6:0] Funct7;
  logic [2:0] Funct3;
  logic in_ready, out_valid, out_mdu, out_illegal, busy, mdu_done;
  logic [OP_W-1:0] Operation;

  logic nm_flush, nm_in_valid, nm_in_ready, nm_out_valid, nm_out_ready;
  logic nm_out_mdu, nm_out_illegal, nm_busy, nm_mdu_done;
  logic [OP_W-1:0] nm_operation;

  exp_t cur_exp;
  exp_t sb_q[$];
  exp_t sb_e;
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .OP_W(OP_W), .ENABLE_M(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .IsImm(IsImm),
    .out_valid(out_valid), .out_ready(out_ready), .Operation(Operation),
    .out_mdu(out_mdu), .out_illegal(out_illegal), .busy(busy), .mdu_done(mdu_done)
  );

  alu_issue_ctrl #(
    .OP_W(OP_W), .ENABLE_M(1'b0), .MUL_LAT(3), .DIV_LAT(33)
  ) dut_nm (
    .clk(clk), .reset(reset), .flush(nm_flush), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .IsImm(IsImm),
    .out_valid(nm_out_valid), .out_ready(nm_out_ready), .Operation(nm_operation),
    .out_mdu(nm_out_mdu), .out_illegal(nm_out_illegal), .busy(nm_busy), .mdu_done(nm_mdu_done)
  );

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_op(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_n(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] a, input logic [6:0] f7, input logic [2:0] f3,
                              input logic imm, input logic [4:0] op, input logic mdu, input logic ill);
    vec_t v;
    v.aluop = a; v.f7 = f7; v.f3 = f3; v.imm = imm;
    v.exp   = '{op: op, mdu: mdu, ill: ill};
    return v;
  endfunction

  // Scoreboard: push on accept, pop on output handshake, flush empties the stage.
  always @(negedge clk) begin
    if (!reset) begin
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: output op %0d with nothing expected at %0t", Operation, $time);
          end else begin
            sb_e = sb_q.pop_front();
            chk_op("sb_op", Operation, sb_e.op);
            chk_b("sb_mdu", out_mdu, sb_e.mdu);
            chk_b("sb_illegal", out_illegal, sb_e.ill);
          end
        end
        if (in_valid && in_ready) sb_q.push_back(cur_exp);
      end
    end
  end

  task automatic set_in(input vec_t v);
    ALUOp = v.aluop; Funct7 = v.f7; Funct3 = v.f3; IsImm = v.imm; cur_exp = v.exp;
  endtask

  task automatic send(input vec_t v);
    int n;
    set_in(v);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at 0 at %0t", $time);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // ALUOp, F7, F3, IsImm -> op, mdu, illegal
    vecs.push_back(mk(2'b10, 7'h00, 3'b000, 1'b0, 5'd0,  1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 7'h20, 3'b000, 1'b0, 5'd1,  1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 7'h20, 3'b000, 1'b1, 5'd0,  1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 7'h20, 3'b001, 1'b1, 5'd0,  1'b0, 1'b1));
    vecs.push_back(mk(2'b10, 7'h20, 3'b101, 1'b1, 5'd7,  1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 7'h00, 3'b101, 1'b1, 5'd6,  1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 7'h7f, 3'b011, 1'b1, 5'd9,  1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 7'h00, 3'b001, 1'b0, 5'd5,  1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 7'h00, 3'b010, 1'b0, 5'd8,  1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 7'h00, 3'b100, 1'b0, 5'd4,  1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 7'h00, 3'b110, 1'b0, 5'd3,  1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 7'h00, 3'b111, 1'b0, 5'd2,  1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 7'h20, 3'b101, 1'b0, 5'd7,  1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 7'h20, 3'b111, 1'b0, 5'd0,  1'b0, 1'b1));
    vecs.push_back(mk(2'b10, 7'h02, 3'b000, 1'b0, 5'd0,  1'b0, 1'b1));
    vecs.push_back(mk(2'b01, 7'h00, 3'b000, 1'b0, 5'd10, 1'b0, 1'b0));
    vecs.push_back(mk(2'b01, 7'h00, 3'b001, 1'b0, 5'd11, 1'b0, 1'b0));
    vecs.push_back(mk(2'b01, 7'h00, 3'b100, 1'b0, 5'd12, 1'b0, 1'b0));
    vecs.push_back(mk(2'b01, 7'h00, 3'b101, 1'b0, 5'd13, 1'b0, 1'b0));
    vecs.push_back(mk(2'b01, 7'h00, 3'b110, 1'b0, 5'd14, 1'b0, 1'b0));
    vecs.push_back(mk(2'b01, 7'h00, 3'b111, 1'b0, 5'd15, 1'b0, 1'b0));
    vecs.push_back(mk(2'b01, 7'h00, 3'b011, 1'b0, 5'd0,  1'b0, 1'b1));
    vecs.push_back(mk(2'b00, 7'h55, 3'b010, 1'b0, 5'd0,  1'b0, 1'b0));
    vecs.push_back(mk(2'b11, 7'h00, 3'b000, 1'b0, 5'd24, 1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 7'h01, 3'b011, 1'b0, 5'd19, 1'b1, 1'b0));
    vecs.push_back(mk(2'b10, 7'h01, 3'b110, 1'b0, 5'd22, 1'b1, 1'b0));
    vecs.push_back(mk(2'b10, 7'h01, 3'b001, 1'b0, 5'd17, 1'b1, 1'b0));
    vecs.push_back(mk(2'b10, 7'h01, 3'b111, 1'b0, 5'd23, 1'b1, 1'b0));

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    nm_flush = 1'b0; nm_in_valid = 1'b0; nm_out_ready = 1'b1;
    set_in(mk(2'b00, 7'h00, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0));

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_op("rst_operation", Operation, 5'd0);
    chk_b("rst_out_mdu", out_mdu, 1'b0);
    chk_b("rst_out_illegal", out_illegal, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_mdu_done", mdu_done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_b("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Back-to-back add then sub, one result per clock
    set_in(mk(2'b10, 7'h00, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_in(mk(2'b10, 7'h20, 3'b000, 1'b0, 5'd1, 1'b0, 1'b0));
    @(negedge clk);
    chk_b("stream_valid0", out_valid, 1'b1);
    chk_op("stream_op0", Operation, 5'd0);
    chk_b("stream_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_b("stream_valid1", out_valid, 1'b1);
    chk_op("stream_op1", Operation, 5'd1);
    @(posedge clk); #1;

    // Decode table streamed through the scoreboard
    for (int i = 0; i < vecs.size(); i++) send(vecs[i]);
    repeat (6) @(posedge clk);
    #1;

    // DIV occupancy: busy for DIV_LAT-1 cycles, mdu_done on the last
    set_in(mk(2'b10, 7'h01, 3'b100, 1'b0, 5'd20, 1'b1, 1'b0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_b("div_valid", out_valid, 1'b1);
    chk_op("div_op", Operation, 5'd20);
    chk_b("div_mdu", out_mdu, 1'b1);
    chk_b("div_busy_pre", busy, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk_b("div_busy", busy, 1'b1);
      chk_b("div_mdu_done", mdu_done, k == 3);
      chk_b("div_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    chk_b("div_busy_post", busy, 1'b0);
    chk_b("div_done_post", mdu_done, 1'b0);
    chk_b("div_in_ready_post", in_ready, 1'b1);
    @(posedge clk); #1;

    // MUL with latency 1: no WAIT, mdu_done on the handshake cycle
    set_in(mk(2'b10, 7'h01, 3'b000, 1'b0, 5'd16, 1'b1, 1'b0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_b("mul_valid", out_valid, 1'b1);
    chk_b("mul_done", mdu_done, 1'b1);
    chk_b("mul_busy", busy, 1'b0);
    @(negedge clk);
    chk_b("mul_done_after", mdu_done, 1'b0);
    chk_b("mul_busy_after", busy, 1'b0);
    @(posedge clk); #1;

    // Op accepted alongside a DIV handshake waits out the occupancy
    set_in(mk(2'b10, 7'h01, 3'b100, 1'b0, 5'd20, 1'b1, 1'b0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_in(mk(2'b10, 7'h00, 3'b111, 1'b0, 5'd2, 1'b0, 1'b0));
    @(negedge clk);
    chk_b("pipe_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_b("pipe_hidden", out_valid, 1'b0);
      chk_b("pipe_busy", busy, 1'b1);
    end
    @(negedge clk);
    chk_b("pipe_valid", out_valid, 1'b1);
    chk_op("pipe_op", Operation, 5'd2);
    @(posedge clk); #1;

    // Output stall: held stable, in_ready low, then release
    out_ready = 1'b0;
    set_in(mk(2'b10, 7'h00, 3'b110, 1'b0, 5'd3, 1'b0, 1'b0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_in(mk(2'b10, 7'h00, 3'b100, 1'b0, 5'd4, 1'b0, 1'b0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_b("stall_in_ready", in_ready, 1'b0);
      chk_b("stall_valid", out_valid, 1'b1);
      chk_op("stall_op", Operation, 5'd3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk_b("stall_release_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_b("stall_next_valid", out_valid, 1'b1);
    chk_op("stall_next_op", Operation, 5'd4);
    @(posedge clk); #1;

    // Flush during DIV WAIT
    set_in(mk(2'b10, 7'h01, 3'b101, 1'b0, 5'd21, 1'b1, 1'b0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_op("fl_div_op", Operation, 5'd21);
    @(posedge clk); #1;
    flush = 1'b1;
    set_in(mk(2'b10, 7'h00, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0));
    in_valid = 1'b1;
    @(negedge clk);
    chk_b("fl_busy_in", busy, 1'b1);
    chk_b("fl_done_in", mdu_done, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk_b("fl_busy", busy, 1'b0);
    chk_b("fl_valid", out_valid, 1'b0);
    chk_b("fl_done", mdu_done, 1'b0);
    chk_b("fl_in_ready", in_ready, 1'b1);
    @(negedge clk);
    chk_b("fl_done_late", mdu_done, 1'b0);
    @(posedge clk); #1;

    // Flush drops a held output and the input offered that cycle
    out_ready = 1'b0;
    set_in(mk(2'b10, 7'h00, 3'b001, 1'b0, 5'd5, 1'b0, 1'b0));
    in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1;
    set_in(mk(2'b10, 7'h00, 3'b100, 1'b0, 5'd4, 1'b0, 1'b0));
    @(negedge clk);
    chk_b("fl2_held_valid", out_valid, 1'b1);
    chk_b("fl2_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk_b("fl2_valid", out_valid, 1'b0);
    @(negedge clk);
    chk_b("fl2_dropped", out_valid, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // ENABLE_M=0: the M encoding is illegal and never occupies the MDU
    set_in(mk(2'b10, 7'h01, 3'b100, 1'b0, 5'd0, 1'b0, 1'b1));
    nm_in_valid = 1'b1;
    @(negedge clk);
    chk_b("nm_in_ready", nm_in_ready, 1'b1);
    @(posedge clk); #1;
    nm_in_valid = 1'b0;
    @(negedge clk);
    chk_b("nm_valid", nm_out_valid, 1'b1);
    chk_b("nm_illegal", nm_out_illegal, 1'b1);
    chk_b("nm_mdu", nm_out_mdu, 1'b0);
    chk_op("nm_op", nm_operation, 5'd0);
    @(negedge clk);
    chk_b("nm_busy", nm_busy, 1'b0);
    chk_b("nm_done", nm_mdu_done, 1'b0);
    chk_b("nm_valid_after", nm_out_valid, 1'b0);

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk_n("sb_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
